// File: rtl/bc_pkg.sv
// Shared types and constants for the bulls-and-cows autoplayer.
package bc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEEK,
    ST_PRESS,
    ST_GAP,
    ST_WAIT,
    ST_SOLVED,
    ST_FAILED
  } bc_state_e;

  localparam int DIGIT_W = 4;
  localparam int GUESS_W = 4 * DIGIT_W;

  localparam logic [GUESS_W-1:0] FIRST_GUESS = 16'h0123;
  localparam logic [3:0]         WIN_BULLS   = 4'd4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bc_bcd_incr.sv
// Four-digit BCD increment with carry-out, plus a
// flag telling whether all four digits differ.
module bc_bcd_incr
  import bc_pkg::*;
(
  input  logic [GUESS_W-1:0] value,
  output logic [GUESS_W-1:0] next,
  output logic               carry,
  output logic               distinct
);

  always_comb begin
    logic c;
    next = value;
    c    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (value[i*DIGIT_W +: DIGIT_W] >= DIGIT_W'(9)) begin
          next[i*DIGIT_W +: DIGIT_W] = '0;
        end else begin
          next[i*DIGIT_W +: DIGIT_W] =
            value[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
          c = 1'b0;
        end
      end
    end
    carry = c;
  end

  always_comb begin
    distinct = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        if (value[i*DIGIT_W +: DIGIT_W] ==
            value[j*DIGIT_W +: DIGIT_W])
          distinct = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bc_autoplayer.sv
// Brute-force bulls-and-cows player: walks distinct-digit
// candidates, presses confirm, and waits for the score.
module bc_autoplayer
  import bc_pkg::*;
#(
  parameter int CONFIRM_HOLD   = 2,
  parameter int CONFIRM_GAP    = 2,
  parameter int RESULT_TIMEOUT = 255
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               result_valid,
  input  logic [3:0]         bulls,
  input  logic [3:0]         cows,
  output logic [GUESS_W-1:0] guess,
  output logic               confirm,
  output logic               busy,
  output logic               solved,
  output logic               failed,
  output logic [12:0]        attempts
);

  localparam int MAXC =
    max3(CONFIRM_HOLD, CONFIRM_GAP, RESULT_TIMEOUT);
  localparam int TW = $clog2(MAXC + 1);

  localparam logic [TW-1:0] HOLD_LD = TW'(CONFIRM_HOLD - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'(CONFIRM_GAP - 1);
  localparam logic [TW-1:0] WAIT_LD = TW'(RESULT_TIMEOUT - 1);

  bc_state_e           state;
  logic [TW-1:0]       timer;
  logic [GUESS_W-1:0]  nxt_guess;
  logic                carry;
  logic                distinct;
  logic                win;
  logic                unused_cows;

  assign unused_cows = ^cows;
  assign win = (bulls == WIN_BULLS);

  bc_bcd_incr u_incr (
    .value    (guess),
    .next     (nxt_guess),
    .carry    (carry),
    .distinct (distinct)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      guess    <= FIRST_GUESS;
      confirm  <= 1'b0;
      attempts <= '0;
      timer    <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_SOLVED, ST_FAILED: begin
          if (start) begin
            state    <= ST_SEEK;
            guess    <= FIRST_GUESS;
            attempts <= '0;
          end
        end
        ST_SEEK: begin
          if (distinct) begin
            state    <= ST_PRESS;
            confirm  <= 1'b1;
            attempts <= attempts + 13'd1;
            timer    <= HOLD_LD;
          end else if (carry) begin
            state <= ST_FAILED;
          end else begin
            guess <= nxt_guess;
          end
        end
        ST_PRESS: begin
          if (timer == '0) begin
            state   <= ST_GAP;
            confirm <= 1'b0;
            timer   <= GAP_LD;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        ST_GAP: begin
          if (timer == '0) begin
            state <= ST_WAIT;
            timer <= WAIT_LD;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        ST_WAIT: begin
          if (result_valid) begin
            timer <= '0;
            if (win)
              state <= ST_SOLVED;
            else if (carry)
              state <= ST_FAILED;
            else begin
              state <= ST_SEEK;
              guess <= nxt_guess;
            end
          end else if (timer == '0) begin
            state <= ST_FAILED;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          confirm <= 1'b0;
        end
      endcase
    end
  end

  assign busy =
    !(state inside {ST_IDLE, ST_SOLVED, ST_FAILED});
  assign solved = (state == ST_SOLVED);
  assign failed = (state == ST_FAILED);

endmodule
